camera_frame_scaler: RTL and testbench
======================================

Name: camera_frame_scaler

Overview:
- Upstream feeder for the pixel stream input of the network top: takes a raw camera pixel stream, crops a centred square window and box-averages it down to OUT_DIM x OUT_DIM pixels.
- Emits the result as a VSYNC/HSYNC-strobed 12-bit stream; one frame = OUT_DIM*OUT_DIM pixels (4096 by default), which is the size of the first network layer.

Parameters:
- dataWidth, 12, pixel width in and out
- SRC_W, 640, active source pixels per line
- SRC_H, 480, active source lines per frame
- OUT_DIM, 64, output frame is OUT_DIM x OUT_DIM
- FACTOR, 4, decimation factor per axis; power of two, >= 2
- X_OFF, 192, first source column of crop window; X_OFF + OUT_DIM*FACTOR <= SRC_W
- Y_OFF, 112, first source line of crop window; Y_OFF + OUT_DIM*FACTOR <= SRC_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cam_pixel  in  dataWidth  source pixel
- cam_valid  in  1  cam_pixel valid this cycle
- cam_hsync  in  1  one-cycle pulse before the first pixel of each source line
- cam_vsync  in  1  one-cycle pulse before the first line of each source frame
- out  out  dataWidth  averaged output pixel, valid while HSYNC=1
- HSYNC  out  1  one-cycle strobe per output pixel
- VSYNC  out  1  one-cycle output frame-start pulse
- frame_err  out  1  one-cycle pulse: previous frame emitted != OUT_DIM*OUT_DIM pixels

Behaviour:
- Reset: out=0, HSYNC=0, VSYNC=0, frame_err=0. All counters, accumulators and the armed flag are cleared. rst wins over every other input in the same cycle.
- Armed flag: set by the first cam_vsync after reset. Pixels arriving before that are ignored, so no partial frame is ever emitted.
- Source counters src_x (column) and src_y (line):
  - cam_vsync: src_y=0, src_x=0.
  - cam_hsync: src_x=0; src_y increments, except on the first hsync after vsync.
  - Each accepted pixel (cam_valid=1, armed) increments src_x.
  - Pixels with src_x >= SRC_W and lines with src_y >= SRC_H are ignored.
  - cam_valid=0 stalls; no state changes.
- Crop: a pixel contributes only if X_OFF <= src_x < X_OFF+OUT_DIM*FACTOR and Y_OFF <= src_y < Y_OFF+OUT_DIM*FACTOR. Local coordinates are lx=src_x-X_OFF and ly=src_y-Y_OFF.
- Accumulators: array of OUT_DIM entries, each dataWidth+2*log2(FACTOR) bits (16 by default), indexed by lx/FACTOR. A contributing pixel is added, zero-extended, to its entry.
- Emit: when the contributing pixel has lx%FACTOR==FACTOR-1 and ly%FACTOR==FACTOR-1, the registered outputs on the next cycle are:
  - out = (acc + pixel) >> 2*log2(FACTOR), truncating
  - HSYNC = 1
  - the entry is cleared in the same cycle
- Latency: 1 cycle from the completing pixel to its HSYNC. Pixels emit in raster order, at most one per cycle.
- VSYNC = cam_vsync delayed 1 cycle (armed frames only, including the arming vsync). VSYNC and HSYNC are never high together; this holds because a vsync pulse is never accompanied by cam_valid.
- Output count: a 13-bit emitted-pixel counter increments on each HSYNC.
  - On cam_vsync, if a frame was in progress and the count != OUT_DIM*OUT_DIM, pulse frame_err together with VSYNC.
  - The counter and all accumulators are then cleared, including on a vsync arriving mid-frame.
- Simultaneous cam_vsync and cam_hsync: treat as vsync (line 0).

Test Plan:
- Full 640x480 frame, every pixel 12'h800 -> one VSYNC, then exactly 4096 HSYNC strobes, all out=12'h800, no frame_err.
- Frame where each 4x4 crop block holds values 0..15 raster order -> every out=7 (sum 120 >> 4); first HSYNC 1 cycle after source pixel (x=195, y=115).
- cam_valid toggled 1/0 every cycle over constant frame 12'hFFF -> 4096 strobes, out=12'hFFF, no overflow (acc max 16'hFFF0 < 2^16), ordering unchanged.
- cam_vsync after only 300 source lines, then a full frame -> frame_err pulse with second VSYNC (count 3008 != 4096); the next frame emits clean 4096 pixels with no carried accumulator values.
- Assert rst mid-frame for 1 cycle -> outputs 0 next cycle; no HSYNC until after the next cam_vsync; that frame emits 4096 pixels and no frame_err.
- Pixels at src_x=640..700 and lines 480..490 with value 12'hFFF around a 12'h000 frame -> all outputs 12'h000, count 4096.

Source files
------------

// File: rtl/camera_frame_scaler.sv
// camera_frame_scaler
// Crops a centred FACTOR*OUT_DIM square window out of a raw camera stream and
// box-averages each FACTOR x FACTOR block into one output pixel, producing an
// OUT_DIM x OUT_DIM frame as a VSYNC/HSYNC-strobed stream.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   cam_pixel  source pixel
//   cam_valid  cam_pixel valid this cycle (0 = stall)
//   cam_hsync  one-cycle pulse before the first pixel of each source line
//   cam_vsync  one-cycle pulse before the first line of each source frame
//   out        averaged output pixel, valid while HSYNC=1
//   HSYNC      one-cycle strobe per output pixel
//   VSYNC      one-cycle output frame-start pulse
//   frame_err  one-cycle pulse with VSYNC: previous frame emitted a wrong pixel count
module camera_frame_scaler #(
    parameter int unsigned dataWidth = 12,
    parameter int unsigned SRC_W     = 640,
    parameter int unsigned SRC_H     = 480,
    parameter int unsigned OUT_DIM   = 64,
    parameter int unsigned FACTOR    = 4,
    parameter int unsigned X_OFF     = 192,
    parameter int unsigned Y_OFF     = 112
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] cam_pixel,
    input  logic                 cam_valid,
    input  logic                 cam_hsync,
    input  logic                 cam_vsync,
    output logic [dataWidth-1:0] out,
    output logic                 HSYNC,
    output logic                 VSYNC,
    output logic                 frame_err
);

    localparam int unsigned LOGF = $clog2(FACTOR);
    localparam int unsigned SH   = 2 * LOGF;
    localparam int unsigned AW   = dataWidth + SH;
    localparam int unsigned CROP = OUT_DIM * FACTOR;
    localparam int unsigned XW   = $clog2(SRC_W + 1);
    localparam int unsigned YW   = $clog2(SRC_H + 1);
    localparam int unsigned IW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [XW-1:0] X_LO  = XW'(X_OFF);
    localparam logic [XW-1:0] X_HI  = XW'(X_OFF + CROP);
    localparam logic [XW-1:0] X_END = XW'(SRC_W);
    localparam logic [YW-1:0] Y_LO  = YW'(Y_OFF);
    localparam logic [YW-1:0] Y_HI  = YW'(Y_OFF + CROP);
    localparam logic [YW-1:0] Y_END = YW'(SRC_H);
    localparam logic [12:0]   FULL  = 13'(OUT_DIM * OUT_DIM);

    logic                armed;
    logic                first_line;
    logic [XW-1:0]       src_x;
    logic [YW-1:0]       src_y;
    logic [12:0]         count;
    logic [AW-1:0]       acc [OUT_DIM];

    logic                in_crop;
    logic [LOGF-1:0]     sub_x;
    logic [LOGF-1:0]     sub_y;
    logic [IW-1:0]       idx;
    logic [AW-1:0]       sum;
    logic                block_done;

    // src_y saturates at SRC_H, so the y window test also rejects lines past the frame.
    assign in_crop    = (src_x >= X_LO) && (src_x < X_HI) && (src_y >= Y_LO) && (src_y < Y_HI);
    assign sub_x      = src_x[LOGF-1:0] - X_LO[LOGF-1:0];
    assign sub_y      = src_y[LOGF-1:0] - Y_LO[LOGF-1:0];
    assign idx        = IW'((src_x - X_LO) >> LOGF);
    assign sum        = acc[idx] + AW'(cam_pixel);
    assign block_done = (&sub_x) && (&sub_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b0;
            first_line <= 1'b0;
            src_x      <= '0;
            src_y      <= '0;
            count      <= '0;
            out        <= '0;
            HSYNC      <= 1'b0;
            VSYNC      <= 1'b0;
            frame_err  <= 1'b0;
            for (int unsigned i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        end else begin
            HSYNC     <= 1'b0;
            VSYNC     <= 1'b0;
            frame_err <= 1'b0;
            if (cam_vsync) begin
                // armed is still 0 on the arming vsync, so no error is raised for it.
                armed      <= 1'b1;
                VSYNC      <= 1'b1;
                frame_err  <= armed && (count != FULL);
                src_x      <= '0;
                src_y      <= '0;
                first_line <= 1'b1;
                count      <= '0;
                for (int unsigned i = 0; i < OUT_DIM; i++) acc[i] <= '0;
            end else if (armed) begin
                if (cam_hsync) begin
                    src_x <= '0;
                    if (first_line)
                        first_line <= 1'b0;
                    else if (src_y < Y_END)
                        src_y <= src_y + 1'b1;
                end else if (cam_valid && (src_x < X_END)) begin
                    src_x <= src_x + 1'b1;
                    if (in_crop) begin
                        if (block_done) begin
                            out        <= dataWidth'(sum >> SH);
                            HSYNC      <= 1'b1;
                            acc[idx]   <= '0;
                            count      <= count + 1'b1;
                        end else begin
                            acc[idx]   <= sum;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_scaler.sv
// Directed bench for camera_frame_scaler on a reduced geometry:
// 16x12 source, 8x8 crop at (4,2), FACTOR 4 -> 2x2 output (4 pixels/frame).
module tb_camera_frame_scaler;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int D  = 2;
    localparam int F  = 4;
    localparam int XO = 4;
    localparam int YO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cam_pixel;
    logic        cam_valid, cam_hsync, cam_vsync;
    logic [11:0] out;
    logic        HSYNC, VSYNC, frame_err;

    camera_frame_scaler #(
        .dataWidth(12), .SRC_W(W), .SRC_H(H), .OUT_DIM(D),
        .FACTOR(F), .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .clk(clk), .rst(rst), .cam_pixel(cam_pixel), .cam_valid(cam_valid),
        .cam_hsync(cam_hsync), .cam_vsync(cam_vsync), .out(out),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // output monitor
    int          hs_cnt, vs_cnt, err_cnt, err_with_vs, first_hs_cyc;
    int          overlap = 0;
    logic [11:0] outs[$];

    always @(negedge clk) begin
        if (HSYNC) begin
            if (hs_cnt == 0) first_hs_cyc = cyc;
            outs.push_back(out);
            hs_cnt++;
        end
        if (VSYNC) vs_cnt++;
        if (frame_err) begin
            err_cnt++;
            if (VSYNC) err_with_vs++;
        end
        if (HSYNC && VSYNC) overlap++;
    end

    task automatic clear_mon();
        hs_cnt = 0; vs_cnt = 0; err_cnt = 0; err_with_vs = 0; first_hs_cyc = -1;
        outs.delete();
    endtask

    logic [11:0] cval;
    int          mark_cyc;

    function automatic logic [11:0] pix(input int mode, input int x, input int y);
        bit crop = (x >= XO) && (x < XO + D * F) && (y >= YO) && (y < YO + D * F);
        case (mode)
            0: return cval;
            1: return crop ? 12'(((y - YO) % F) * F + (x - XO) % F) : 12'hABC;
            2: return (x < W && y < H) ? 12'h000 : 12'hFFF;
            default: return crop ? 12'(256 * (((y - YO) / F) * D + (x - XO) / F + 1)) : 12'h000;
        endcase
    endfunction

    task automatic drive(input logic v, input logic hs, input logic vs, input logic [11:0] p);
        cam_valid = v; cam_hsync = hs; cam_vsync = vs; cam_pixel = p;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic send_frame(input int mode, input int nlines, input int ncols,
                              input bit stall, input bit do_vsync);
        if (do_vsync) drive(1'b0, 1'b0, 1'b1, 12'h000);
        for (int y = 0; y < nlines; y++) begin
            drive(1'b0, 1'b1, 1'b0, 12'h000);
            for (int x = 0; x < ncols; x++) begin
                if (mode == 1 && x == XO + F - 1 && y == YO + F - 1) mark_cyc = cyc;
                drive(1'b1, 1'b0, 1'b0, pix(mode, x, y));
                if (stall) drive(1'b0, 1'b0, 1'b0, 12'h123);
            end
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL reset_out: got %h want 000", out); end
        checks++; if (HSYNC !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b want 0", HSYNC); end
        checks++; if (VSYNC !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", VSYNC); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst = 1'b0;
        // not armed yet: a whole frame without vsync must produce nothing
        clear_mon();
        cval = 12'hFFF;
        send_frame(0, H, W, 1'b0, 1'b0);
        checks++; if (hs_cnt !== 0) begin errors++; $display("FAIL unarmed_hsync: got %0d want 0", hs_cnt); end
        // rst wins over a simultaneous vsync
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 12'h000);
        rst = 1'b0;
        send_frame(0, H, W, 1'b0, 1'b0);
        checks++; if (hs_cnt !== 0) begin errors++; $display("FAIL rst_vs_hsync: got %0d want 0", hs_cnt); end
        checks++; if (vs_cnt !== 0) begin errors++; $display("FAIL rst_vs_vsync: got %0d want 0", vs_cnt); end
    endtask

    task automatic test_const();
        clear_mon();
        cval = 12'h800;
        send_frame(0, H, W, 1'b0, 1'b1);
        checks++; if (vs_cnt !== 1) begin errors++; $display("FAIL const_vsync: got %0d want 1", vs_cnt); end
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL const_hs_count: got %0d want 4", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL const_frame_err: got %0d want 0", err_cnt); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'h800) begin errors++; $display("FAIL const_out[%0d]: got %h want 800", i, outs[i]); end
        end
    endtask

    task automatic test_pattern();
        clear_mon();
        send_frame(1, H, W, 1'b0, 1'b1);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL pattern_hs_count: got %0d want 4", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL pattern_frame_err: got %0d want 0", err_cnt); end
        checks++; if (first_hs_cyc !== mark_cyc + 1) begin errors++; $display("FAIL pattern_latency: got cycle %0d want %0d", first_hs_cyc, mark_cyc + 1); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'd7) begin errors++; $display("FAIL pattern_out[%0d]: got %h want 007", i, outs[i]); end
        end
    endtask

    task automatic test_stall();
        clear_mon();
        cval = 12'hFFF;
        send_frame(0, H, W, 1'b1, 1'b1);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL stall_hs_count: got %0d want 4", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL stall_frame_err: got %0d want 0", err_cnt); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'hFFF) begin errors++; $display("FAIL stall_out[%0d]: got %h want fff", i, outs[i]); end
        end
    endtask

    task automatic test_order();
        logic [11:0] exp_o[4] = '{12'h100, 12'h200, 12'h300, 12'h400};
        clear_mon();
        send_frame(3, H, W, 1'b0, 1'b1);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL order_hs_count: got %0d want 4", hs_cnt); end
        foreach (outs[i]) begin
            if (i < 4) begin
                checks++; if (outs[i] !== exp_o[i]) begin errors++; $display("FAIL order_out[%0d]: got %h want %h", i, outs[i], exp_o[i]); end
            end
        end
    endtask

    task automatic test_short_frame();
        clear_mon();
        cval = 12'hFFF;
        send_frame(0, 8, W, 1'b0, 1'b1);
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL short_hs_count: got %0d want 2", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL short_frame_err: got %0d want 0", err_cnt); end
        clear_mon();
        cval = 12'h400;
        send_frame(0, H, W, 1'b0, 1'b1);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL after_short_err: got %0d want 1", err_cnt); end
        checks++; if (err_with_vs !== 1) begin errors++; $display("FAIL after_short_err_vs: got %0d want 1", err_with_vs); end
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL after_short_hs_count: got %0d want 4", hs_cnt); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'h400) begin errors++; $display("FAIL after_short_out[%0d]: got %h want 400", i, outs[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        cval = 12'h2AA;
        send_frame(0, 7, W, 1'b0, 1'b1);
        checks++; if (out !== 12'h2AA) begin errors++; $display("FAIL mid_pre_out: got %h want 2aa", out); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        rst = 1'b0;
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL mid_rst_out: got %h want 000", out); end
        checks++; if (HSYNC !== 1'b0) begin errors++; $display("FAIL mid_rst_hsync: got %b want 0", HSYNC); end
        send_frame(0, H, W, 1'b0, 1'b0);
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL mid_no_hsync: got %0d want 2", hs_cnt); end
        clear_mon();
        cval = 12'h555;
        send_frame(0, H, W, 1'b0, 1'b1);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL mid_next_hs_count: got %0d want 4", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL mid_next_err: got %0d want 0", err_cnt); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'h555) begin errors++; $display("FAIL mid_next_out[%0d]: got %h want 555", i, outs[i]); end
        end
    endtask

    task automatic test_out_of_bounds();
        clear_mon();
        send_frame(2, H + 3, W + 5, 1'b0, 1'b1);
        checks++; if (hs_cnt !== 4) begin errors++; $display("FAIL oob_hs_count: got %0d want 4", hs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL oob_frame_err: got %0d want 0", err_cnt); end
        foreach (outs[i]) begin
            checks++; if (outs[i] !== 12'h000) begin errors++; $display("FAIL oob_out[%0d]: got %h want 000", i, outs[i]); end
        end
    endtask

    task automatic test_final();
        clear_mon();
        drive(1'b0, 1'b0, 1'b1, 12'h000);
        idle(3);
        checks++; if (vs_cnt !== 1) begin errors++; $display("FAIL final_vsync: got %0d want 1", vs_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL final_frame_err: got %0d want 0", err_cnt); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL hs_vs_overlap: got %0d want 0", overlap); end
    endtask

    initial begin
        rst = 1'b1; cam_valid = 1'b0; cam_hsync = 1'b0; cam_vsync = 1'b0; cam_pixel = '0;
        cval = '0; mark_cyc = -1;
        clear_mon();
        @(posedge clk); #1;
        test_reset();
        test_const();
        test_pattern();
        test_stall();
        test_order();
        test_short_frame();
        test_reset_mid();
        test_out_of_bounds();
        test_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
